// File: rtl/autosym_pla_pkg.sv
// Shared types and field-layout helpers for the autosymmetric PLA evaluator.
// Optional output inversion is enabled by defining AUTOSYM_OUT_INV_EN.
package autosym_pla_pkg;

    typedef enum logic [1:0] {
        CFG_LAMBDA = 2'd0,
        CFG_CUBE   = 2'd1,
        CFG_INV    = 2'd2,
        CFG_RSVD   = 2'd3
    } cfg_kind_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cfg_w(input int n_in, input int k_red,
                                 input int n_out);
        return max2(n_in, 2 * k_red + n_out + 1);
    endfunction

    function automatic int idx_w(input int k_red, input int n_cubes);
        int m;
        m = max2(k_red, n_cubes);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Cube payload layout, LSB first: care | val | omask | en
    function automatic int care_lo(input int k_red);
        return 0 * k_red;
    endfunction

    function automatic int val_lo(input int k_red);
        return k_red;
    endfunction

    function automatic int omask_lo(input int k_red);
        return 2 * k_red;
    endfunction

    function automatic int en_bit(input int k_red, input int n_out);
        return 2 * k_red + n_out;
    endfunction

endpackage

// File: rtl/autosym_cube_array.sv
// Cube storage, cube write decode and the combinational hit/OR plane over z.
// Hit output is registered by the caller's second pipeline stage.
module autosym_cube_array
    import autosym_pla_pkg::*;
#(
    parameter int K_RED   = 4,
    parameter int N_CUBES = 16,
    parameter int N_OUT   = 1,
    parameter int CFG_W   = 10,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [CFG_W-1:0] i_data,
    input  logic [K_RED-1:0] i_z,
    output logic [N_OUT-1:0] o_hit
);

    localparam int CARE_LO  = care_lo(K_RED);
    localparam int VAL_LO   = val_lo(K_RED);
    localparam int OMASK_LO = omask_lo(K_RED);
    localparam int EN_BIT   = en_bit(K_RED, N_OUT);

    logic [K_RED-1:0]   r_care  [N_CUBES];
    logic [K_RED-1:0]   r_val   [N_CUBES];
    logic [N_OUT-1:0]   r_omask [N_CUBES];
    logic [N_CUBES-1:0] r_en;

    // Payload bits above the en field carry no meaning.
    logic w_unused_data;
    assign w_unused_data = ^i_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en <= '0;
            for (int c = 0; c < N_CUBES; c++) begin
                r_care[c]  <= '0;
                r_val[c]   <= '0;
                r_omask[c] <= '0;
            end
        end else if (i_we) begin
            for (int c = 0; c < N_CUBES; c++) begin
                if (i_idx == IDX_W'(c)) begin
                    r_care[c]  <= i_data[CARE_LO +: K_RED];
                    r_val[c]   <= i_data[VAL_LO +: K_RED];
                    r_omask[c] <= i_data[OMASK_LO +: N_OUT];
                    r_en[c]    <= i_data[EN_BIT];
                end
            end
        end
    end

    always_comb begin
        o_hit = '0;
        for (int c = 0; c < N_CUBES; c++) begin
            if (r_en[c] && (((i_z ^ r_val[c]) & r_care[c]) == '0))
                o_hit = o_hit | r_omask[c];
        end
    end

endmodule

// File: rtl/autosym_pla_eval.sv
// Two-stage evaluator f(x) = g(lambda(x)): GF(2) compression then cube PLA.
// Define AUTOSYM_OUT_INV_EN to add the per-output inversion mask.
module autosym_pla_eval
    import autosym_pla_pkg::*;
#(
    parameter int N_IN    = 8,
    parameter int K_RED   = 4,
    parameter int N_CUBES = 16,
    parameter int N_OUT   = 1,
    localparam int CFG_W  = cfg_w(N_IN, K_RED, N_OUT),
    localparam int IDX_W  = idx_w(K_RED, N_CUBES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_kind,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_y
);

    logic [N_IN-1:0]  r_lam [K_RED];
    logic             r_s1_valid;
    logic [K_RED-1:0] r_z;
    logic             r_s2_valid;
    logic [N_OUT-1:0] r_y;

    cfg_kind_e        w_kind;
    logic             w_cfg_fire;
    logic             w_in_fire;
    logic             w_s1_en;
    logic             w_s2_adv;
    logic [K_RED-1:0] w_z;
    logic [N_OUT-1:0] w_hit;
    logic [N_OUT-1:0] w_y_next;

    assign w_kind     = cfg_kind_e'(cfg_kind);
    assign w_s2_adv   = ~r_s2_valid | out_ready;
    assign w_s1_en    = ~r_s1_valid | w_s2_adv;
    assign cfg_ready  = ~r_s1_valid & ~r_s2_valid;
    assign in_ready   = ~cfg_valid & w_s1_en;
    assign w_cfg_fire = cfg_valid & cfg_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign out_valid  = r_s2_valid;
    assign out_y      = r_y;

    // Default matrix projects x onto its low K_RED bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < K_RED; i++)
                r_lam[i] <= N_IN'(1) << i;
        end else if (w_cfg_fire && (w_kind == CFG_LAMBDA)) begin
            for (int i = 0; i < K_RED; i++) begin
                if (cfg_idx == IDX_W'(i))
                    r_lam[i] <= cfg_data[N_IN-1:0];
            end
        end
    end

    always_comb begin
        w_z = '0;
        for (int i = 0; i < K_RED; i++)
            w_z[i] = ^(in_x & r_lam[i]);
    end

    autosym_cube_array #(
        .K_RED   (K_RED),
        .N_CUBES (N_CUBES),
        .N_OUT   (N_OUT),
        .CFG_W   (CFG_W),
        .IDX_W   (IDX_W)
    ) u_cubes (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_cfg_fire && (w_kind == CFG_CUBE)),
        .i_idx  (cfg_idx),
        .i_data (cfg_data),
        .i_z    (r_z),
        .o_hit  (w_hit)
    );

`ifdef AUTOSYM_OUT_INV_EN
    logic [N_OUT-1:0] r_inv;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_inv <= '0;
        else if (w_cfg_fire && (w_kind == CFG_INV))
            r_inv <= cfg_data[N_OUT-1:0];
    end

    assign w_y_next = w_hit ^ r_inv;
`else
    assign w_y_next = w_hit;
`endif

    // Config is only accepted when empty, so cube state never changes under r_z.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_z        <= '0;
            r_s2_valid <= 1'b0;
            r_y        <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= w_in_fire;
                if (w_in_fire)
                    r_z <= w_z;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid)
                    r_y <= w_y_next;
            end
        end
    end

endmodule

// File: tb/tb_autosym_pla_eval.sv
// Directed bench for autosym_pla_eval: defaults, lambda, cubes, flow control.
// Expectations for the inversion mask follow AUTOSYM_OUT_INV_EN.
module tb_autosym_pla_eval;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_kind;
    logic [3:0] cfg_idx;
    logic [9:0] cfg_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] out_y;

    int total = 0;
    int bad   = 0;

`ifdef AUTOSYM_OUT_INV_EN
    localparam logic INV_ON = 1'b1;
`else
    localparam logic INV_ON = 1'b0;
`endif

    autosym_pla_eval dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_kind  (cfg_kind),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_kind  = 2'd0;
        cfg_idx   = 4'd0;
        cfg_data  = 10'd0;
        in_valid  = 1'b0;
        in_x      = 8'd0;
        out_ready = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] k, input logic [3:0] idx,
                             input logic [9:0] d);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_kind  = k;
        cfg_idx   = idx;
        cfg_data  = d;
        #1;
        while (!cfg_ready && n < 20) begin
            tick;
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL cfg_timeout: cfg_ready got 0 want 1");
        end
        tick;
        cfg_valid = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [7:0] x,
                           input logic exp);
        in_valid  = 1'b1;
        in_x      = x;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        tick;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_early: out_valid got %b want 0", name, out_valid);
        end
        tick;
        total++;
        if (out_valid !== 1'b1 || out_y !== exp) begin
            bad++;
            $display("FAIL %s: valid=%b y=%b want valid=1 y=%b",
                     name, out_valid, out_y, exp);
        end
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        total++;
        if (out_valid !== 1'b0 || out_y !== 1'b0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: valid=%b y=%b cfg_ready=%b want 0 0 1",
                     out_valid, out_y, cfg_ready);
        end
        run_vec("reset_a5", 8'hA5, INV_ON & 1'b0);
    endtask

    task automatic test_projection;
        do_reset;
        cfg_write(2'd1, 4'd0, 10'h35F);
        run_vec("proj_35", 8'h35, 1'b1);
        run_vec("proj_34", 8'h34, 1'b0);
        run_vec("proj_f5", 8'hF5, 1'b1);
        cfg_write(2'd1, 4'd0, 10'h200);
        run_vec("omask0", 8'h35, 1'b0);
    endtask

    task automatic test_lambda;
        do_reset;
        cfg_write(2'd0, 4'd0, 10'h003);
        cfg_write(2'd1, 4'd0, 10'h311);
        run_vec("lam_01", 8'h01, 1'b1);
        run_vec("lam_03", 8'h03, 1'b0);
        run_vec("lam_02", 8'h02, 1'b1);
    endtask

    task automatic test_backpressure;
        logic [7:0] vec [5];
        logic       exp_q [$];
        logic       e;
        logic       prev_stall;
        logic       prev_y;
        int         sent;
        int         rcvd;
        vec[0] = 8'h01; vec[1] = 8'h00; vec[2] = 8'h03;
        vec[3] = 8'h02; vec[4] = 8'h05;
        sent = 0;
        rcvd = 0;
        prev_stall = 1'b0;
        prev_y = 1'b0;
        do_reset;
        cfg_write(2'd1, 4'd0, 10'h311);
        for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
            in_valid  = (sent < 5);
            in_x      = (sent < 5) ? vec[sent] : 8'h00;
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_y !== prev_y) begin
                    bad++;
                    $display("FAIL bp_hold: valid=%b y=%b want 1 %b",
                             out_valid, out_y, prev_y);
                end
            end
            if ((sent - rcvd) == 2 && !out_ready) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_in_ready: got %b want 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra: got output %b want none", out_y);
                end else begin
                    e = exp_q.pop_front();
                    if (out_y !== e) begin
                        bad++;
                        $display("FAIL bp_data%0d: got %b want %b",
                                 rcvd, out_y, e);
                    end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(vec[sent][0]);
                sent++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_y = out_y;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (rcvd != 5 || sent != 5) begin
            bad++;
            $display("FAIL bp_count: sent=%0d rcvd=%0d want 5 5", sent, rcvd);
        end
        tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_tail: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_cfg_arb;
        do_reset;
        in_valid  = 1'b1;
        in_x      = 8'h01;
        out_ready = 1'b0;
        tick;
        in_valid  = 1'b0;
        cfg_valid = 1'b1;
        cfg_kind  = 2'd1;
        cfg_idx   = 4'd0;
        cfg_data  = 10'h311;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL arb_busy1: cfg_ready got %b want 0", cfg_ready);
        end
        tick;
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL arb_busy2: cfg_ready got %b want 0", cfg_ready);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_y !== 1'b0) begin
            bad++;
            $display("FAIL arb_old_cfg: valid=%b y=%b want 1 0",
                     out_valid, out_y);
        end
        tick;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL arb_drained: cfg_ready got %b want 1", cfg_ready);
        end
        tick;
        cfg_valid = 1'b0;
        run_vec("arb_applied", 8'h01, 1'b1);
        cfg_valid = 1'b1;
        cfg_kind  = 2'd1;
        cfg_idx   = 4'd0;
        cfg_data  = 10'h000;
        in_valid  = 1'b1;
        in_x      = 8'h01;
        #1;
        total++;
        if (in_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL arb_same: in_ready=%b cfg_ready=%b want 0 1",
                     in_ready, cfg_ready);
        end
        tick;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        tick;
        tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL arb_no_vec: out_valid got %b want 0", out_valid);
        end
        run_vec("arb_cfg_won", 8'h01, 1'b0);
    endtask

    task automatic test_edges;
        do_reset;
        cfg_write(2'd1, 4'd0, 10'h311);
        cfg_write(2'd0, 4'd4, 10'h000);
        run_vec("oob_lam4", 8'h01, 1'b1);
        cfg_write(2'd0, 4'd15, 10'h000);
        run_vec("oob_lam15", 8'h01, 1'b1);
        cfg_write(2'd3, 4'd0, 10'h000);
        run_vec("rsvd_kind", 8'h01, 1'b1);
        cfg_write(2'd2, 4'd0, 10'h001);
        run_vec("inv_hit", 8'h01, ~INV_ON);
        run_vec("inv_miss", 8'h00, INV_ON);
    endtask

    task automatic test_reset_mid;
        do_reset;
        cfg_write(2'd1, 4'd0, 10'h311);
        in_valid  = 1'b1;
        in_x      = 8'h01;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick;
        total++;
        if (out_valid !== 1'b0 || out_y !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: valid=%b y=%b want 0 0",
                     out_valid, out_y);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_emit%0d: out_valid got %b want 0",
                         i, out_valid);
            end
        end
        run_vec("mid_reset_cube", 8'h01, 1'b0);
    endtask

`ifdef AUTOSYM_OUT_INV_EN
    task automatic test_inv;
        do_reset;
        cfg_write(2'd2, 4'd0, 10'h001);
        run_vec("inv_a5", 8'hA5, 1'b1);
        run_vec("inv_3c", 8'h3C, 1'b1);
    endtask
`endif

    initial begin
        test_reset;
        test_projection;
        test_lambda;
        test_backpressure;
        test_cfg_arb;
        test_edges;
        test_reset_mid;
`ifdef AUTOSYM_OUT_INV_EN
        test_inv;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
